// File: rtl/als_spi_responder.sv
// SPI responder that reports an 8-bit ambient-light sample as a 16-bit frame.
// Optional MOSI word capture is enabled by defining ALS_RESP_MOSI_CAPTURE_EN.
module als_spi_responder #(
   parameter int CPOL        = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_SPI_Clk,
   input  logic        i_SPI_CS_n,
   input  logic        i_SPI_MOSI,
   output logic        o_SPI_MISO,
   input  logic [7:0]  i_Sample,
   input  logic        i_Sample_Valid,
   output logic        o_Busy,
   output logic        o_Frame_Done,
   output logic        o_Short_Frame,
   output logic [15:0] o_Frame_Count
`ifdef ALS_RESP_MOSI_CAPTURE_EN
   ,
   output logic [15:0] o_MOSI_Word
`endif
);

   localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_WAIT_CS = 2'd3
   } state_t;

   state_t                   state_r, next_state_s;
   logic [SYNC_STAGES-1:0]   sclk_sync_r, cs_sync_r;
   logic                     sclk_d_r, cs_d_r;
   logic                     sclk_s, cs_s, lead_s, trail_s, cs_fall_s;
   logic [7:0]               hold_r;
   logic [15:0]              shift_r, shift_next_s, load_word_s;
   logic [3:0]               bit_cnt_r, cnt_next_s;
   logic                     miso_r, miso_next_s;
   logic                     busy_r, done_r, short_r, done_s, short_s;
   logic [15:0]              frame_count_r;

   // CS_n synchronizer resets low so a CS held low through reset cannot open a frame
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         sclk_sync_r <= {SYNC_STAGES{IDLE_LVL}};
         cs_sync_r   <= '0;
         sclk_d_r    <= IDLE_LVL;
         cs_d_r      <= 1'b0;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i_SPI_Clk};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_SPI_CS_n};
         sclk_d_r    <= sclk_s;
         cs_d_r      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
   assign cs_s      = cs_sync_r[SYNC_STAGES-1];
   assign lead_s    = (sclk_d_r == IDLE_LVL) && (sclk_s != IDLE_LVL);
   assign trail_s   = (sclk_d_r != IDLE_LVL) && (sclk_s == IDLE_LVL);
   assign cs_fall_s = cs_d_r && !cs_s;

   // Sample holding register
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         hold_r <= 8'h00;
      end else if (i_Sample_Valid) begin
         hold_r <= i_Sample;
      end
   end

   // A strobe landing on the LOAD cycle bypasses the holding register
   assign load_word_s = {3'b000, (i_Sample_Valid ? i_Sample : hold_r), 5'b00000};

   // Next-state and datapath decode
   always_comb begin
      next_state_s = state_r;
      shift_next_s = shift_r;
      cnt_next_s   = bit_cnt_r;
      miso_next_s  = 1'b0;
      done_s       = 1'b0;
      short_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cs_fall_s) begin
               next_state_s = ST_LOAD;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            shift_next_s = load_word_s;
            cnt_next_s   = 4'd0;
            if (cs_s) begin
               next_state_s = ST_IDLE;
               short_s      = 1'b1;
            end else begin
               next_state_s = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_s) begin
               next_state_s = ST_IDLE;
               short_s      = 1'b1;
            end else if (lead_s) begin
               miso_next_s  = shift_r[15];
               shift_next_s = {shift_r[14:0], 1'b0};
            end else if (trail_s) begin
               cnt_next_s = bit_cnt_r + 4'd1;
               if (bit_cnt_r == 4'd15) begin
                  done_s       = 1'b1;
                  next_state_s = ST_WAIT_CS;
               end else begin
                  miso_next_s  = miso_r;
               end
            end else begin
               miso_next_s = miso_r;
            end
         end
         ST_WAIT_CS: begin
            if (cs_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT_CS;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, shift path and registered outputs
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_r       <= ST_IDLE;
         shift_r       <= 16'h0000;
         bit_cnt_r     <= 4'd0;
         miso_r        <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         short_r       <= 1'b0;
         frame_count_r <= 16'h0000;
      end else begin
         state_r   <= next_state_s;
         shift_r   <= shift_next_s;
         bit_cnt_r <= cnt_next_s;
         miso_r    <= miso_next_s;
         busy_r    <= (next_state_s != ST_IDLE);
         done_r    <= done_s;
         short_r   <= short_s;
         if (done_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end
      end
   end

   assign o_SPI_MISO    = miso_r;
   assign o_Busy        = busy_r;
   assign o_Frame_Done  = done_r;
   assign o_Short_Frame = short_r;
   assign o_Frame_Count = frame_count_r;

`ifdef ALS_RESP_MOSI_CAPTURE_EN
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   mosi_d_r;
   logic [15:0]            mosi_shift_r, mosi_word_r;

   // MOSI follows the same synchronizer depth as SCLK so bits line up with edges
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         mosi_sync_r  <= '0;
         mosi_d_r     <= 1'b0;
         mosi_shift_r <= 16'h0000;
         mosi_word_r  <= 16'h0000;
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_SPI_MOSI};
         mosi_d_r    <= mosi_sync_r[SYNC_STAGES-1];
         if ((state_r == ST_SHIFT) && !cs_s && trail_s) begin
            mosi_shift_r <= {mosi_shift_r[14:0], mosi_d_r};
         end
         if (done_s) begin
            mosi_word_r <= {mosi_shift_r[14:0], mosi_d_r};
         end
      end
   end

   assign o_MOSI_Word = mosi_word_r;
`else
   logic unused_mosi_s;
   assign unused_mosi_s = i_SPI_MOSI;
`endif

endmodule

// File: tb/tb_als_spi_responder.sv
// Directed self-checking bench for als_spi_responder (CPOL=1, SYNC_STAGES=2),
// acting as a mode-3 SPI master with a half-period of 5 system clocks.
module tb_als_spi_responder;

   localparam logic CPOL_LVL = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = CPOL_LVL;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [7:0]  sample = 8'h00;
   logic        sample_valid = 1'b0;
   logic        busy, frame_done, short_frame;
   logic [15:0] frame_count;
`ifdef ALS_RESP_MOSI_CAPTURE_EN
   logic [15:0] mosi_word;
`endif

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int short_seen = 0;

   als_spi_responder #(.CPOL(1), .SYNC_STAGES(2)) dut (
      .i_Clk          (clk),
      .i_Reset        (rst),
      .i_SPI_Clk      (sclk),
      .i_SPI_CS_n     (cs_n),
      .i_SPI_MOSI     (mosi),
      .o_SPI_MISO     (miso),
      .i_Sample       (sample),
      .i_Sample_Valid (sample_valid),
      .o_Busy         (busy),
      .o_Frame_Done   (frame_done),
      .o_Short_Frame  (short_frame),
      .o_Frame_Count  (frame_count)
`ifdef ALS_RESP_MOSI_CAPTURE_EN
      ,
      .o_MOSI_Word    (mosi_word)
`endif
   );

   always #5 clk = ~clk;

   // Counts high cycles of each pulse output
   always @(negedge clk) begin
      if (frame_done) done_seen <= done_seen + 1;
      if (short_frame) short_seen <= short_seen + 1;
   end

   task automatic strobe(input logic [7:0] v);
      sample = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // n SCLK periods; MISO captured just before each trailing (rising) edge
   task automatic spi_clocks(input int n, input logic [15:0] mo, output logic [31:0] rd);
      rd = 32'd0;
      for (int k = 0; k < n; k++) begin
         sclk = ~CPOL_LVL;
         mosi = (k < 16) ? mo[15-k] : 1'b0;
         repeat (5) @(negedge clk);
         rd = {rd[30:0], miso};
         sclk = CPOL_LVL;
         repeat (5) @(negedge clk);
      end
      mosi = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
      total++; if (short_frame !== 1'b0) begin bad++; $display("FAIL reset_short got=%b want=0", short_frame); end
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h want=0000", frame_count); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      logic [31:0] rd;
      int d0;
      strobe(8'hA5);
      d0 = done_seen;
      cs_low();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL basic_miso_pre got=%b want=0", miso); end
      spi_clocks(16, 16'h0000, rd);
      cs_high();
      total++; if (rd[15:0] !== 16'h14A0) begin bad++; $display("FAIL basic_word got=%h want=14a0", rd[15:0]); end
      total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_seen - d0); end
      total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%h want=0001", frame_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      strobe(8'h5A);
      cs_low();
      spi_clocks(16, 16'h0000, rd);
      cs_high();
      total++; if (rd[15:0] !== 16'h0B40) begin bad++; $display("FAIL b2b_word got=%h want=0b40", rd[15:0]); end
      total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%h want=0002", frame_count); end
   endtask

   task automatic test_bypass();
      logic [31:0] rd;
      int waited;
      strobe(8'h11);
      cs_n = 1'b0;
      waited = 0;
      while (!busy && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bypass_load_wait got=%b want=1", busy); end
      sample = 8'h3C;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      spi_clocks(16, 16'h0000, rd);
      cs_high();
      total++; if (rd[15:0] !== 16'h0780) begin bad++; $display("FAIL bypass_word got=%h want=0780", rd[15:0]); end
      total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL bypass_count got=%h want=0003", frame_count); end
   endtask

   task automatic test_short_frame();
      logic [31:0] rd;
      int s0, d0;
      s0 = short_seen;
      d0 = done_seen;
      cs_low();
      spi_clocks(9, 16'h0000, rd);
      cs_high();
      total++; if (rd[8:0] !== 9'h00F) begin bad++; $display("FAIL short_bits got=%h want=00f", rd[8:0]); end
      total++; if (short_seen - s0 !== 1) begin bad++; $display("FAIL short_pulse got=%0d want=1", short_seen - s0); end
      total++; if (done_seen - d0 !== 0) begin bad++; $display("FAIL short_done got=%0d want=0", done_seen - d0); end
      total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL short_count got=%h want=0003", frame_count); end
      cs_low();
      spi_clocks(16, 16'h0000, rd);
      cs_high();
      total++; if (rd[15:0] !== 16'h0780) begin bad++; $display("FAIL short_next_word got=%h want=0780", rd[15:0]); end
      total++; if (frame_count !== 16'd4) begin bad++; $display("FAIL short_next_count got=%h want=0004", frame_count); end
      total++; if (short_seen - s0 !== 1) begin bad++; $display("FAIL short_next_pulse got=%0d want=1", short_seen - s0); end
   endtask

   task automatic test_overrun();
      logic [31:0] rd;
      int d0;
      strobe(8'hFF);
      d0 = done_seen;
      cs_low();
      spi_clocks(20, 16'h0000, rd);
      cs_high();
      total++; if (rd[19:0] !== 20'h1FE00) begin bad++; $display("FAIL overrun_bits got=%h want=1fe00", rd[19:0]); end
      total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL overrun_done got=%0d want=1", done_seen - d0); end
      total++; if (frame_count !== 16'd5) begin bad++; $display("FAIL overrun_count got=%h want=0005", frame_count); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      int d0, s0;
      strobe(8'hA5);
      cs_low();
      spi_clocks(7, 16'h0000, rd);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      d0 = done_seen;
      s0 = short_seen;
      spi_clocks(16, 16'h0000, rd);
      total++; if (rd[15:0] !== 16'h0000) begin bad++; $display("FAIL rstmid_miso got=%h want=0000", rd[15:0]); end
      total++; if (done_seen - d0 !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_seen - d0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%h want=0000", frame_count); end
      cs_high();
      total++; if (short_seen - s0 !== 0) begin bad++; $display("FAIL rstmid_short got=%0d want=0", short_seen - s0); end
      strobe(8'h81);
      cs_low();
      spi_clocks(16, 16'h0000, rd);
      cs_high();
      total++; if (rd[15:0] !== 16'h1020) begin bad++; $display("FAIL rstmid_next_word got=%h want=1020", rd[15:0]); end
      total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL rstmid_next_count got=%h want=0001", frame_count); end
   endtask

   task automatic test_count_wrap();
      logic [31:0] rd;
      int d0;
      force dut.frame_count_r = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_r;
      @(negedge clk);
      total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", frame_count); end
      d0 = done_seen;
      cs_low();
      spi_clocks(16, 16'hBEEF, rd);
      cs_high();
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h want=0000", frame_count); end
      total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", done_seen - d0); end
      total++; if (rd[15:0] !== 16'h1020) begin bad++; $display("FAIL wrap_word got=%h want=1020", rd[15:0]); end
`ifdef ALS_RESP_MOSI_CAPTURE_EN
      total++; if (mosi_word !== 16'hBEEF) begin bad++; $display("FAIL mosi_word got=%h want=beef", mosi_word); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_bypass();
      test_short_frame();
      test_overrun();
      test_reset_midframe();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
